// File: rtl/fullsend_pkg.sv
// Purpose: shared decode constants, MEM-stage FSM state type, store lane helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package fullsend_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Byte enables for a store; funct3[1:0] selects byte/half/word.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3[1:0])
      2'b00:   store_be = 4'b0001 << a;
      2'b01:   store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'hF;
    endcase
  endfunction

  // Store data replicated across every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] b);
    case (funct3[1:0])
      2'b00:   store_wdata = {4{b[7:0]}};
      2'b01:   store_wdata = {2{b[15:0]}};
      default: store_wdata = b;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Purpose: extract and extend load data from a 32-bit read word.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (raw memory word), funct3 (load width/sign), addr_lo (byte offset), lmd (result).
module load_align
  import fullsend_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] lmd
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[8*addr_lo +: 8];
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    lmd = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   lmd = {24'd0, sel_byte};
      F3_H:    lmd = {{16{sel_half[15]}}, sel_half};
      F3_HU:   lmd = {16'd0, sel_half};
      default: lmd = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: MEM pipeline stage; issues data-memory load/store, registers the MEM/WB bundle.
// Latency: 1 cycle for pass-through; >=2 cycles for memory ops (issue + ack), timeout after ACK_MAX.
// Backpressure: stall_o holds upstream while a memory transaction is being issued or awaited.
// Ports: EX/MEM bundle in (ex_mem_*), req/ack data-memory port (dmem_*), MEM/WB bundle out
//        (mem_wb_*), fwd_mem_data bypass for execute, mem_fault timeout/misalign pulse.
// Config: define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of truncating.
module mem_access_stage
  import fullsend_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ACK_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] ex_mem_ir,
  input  logic [XLEN-1:0] ex_mem_alu,
  input  logic [XLEN-1:0] ex_mem_b,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall_o,
  output logic            mem_wb_valid,
  output logic [XLEN-1:0] mem_wb_ir,
  output logic [XLEN-1:0] mem_wb_alu,
  output logic [XLEN-1:0] mem_wb_lmd,
  output logic [XLEN-1:0] fwd_mem_data,
  output logic            mem_fault
);

  localparam int CW = $clog2(ACK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_MAX - 1);

  mem_state_t      state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] op_ir;
  logic [XLEN-1:0] op_alu;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load;
  logic            is_store;
  logic            is_mem;
  logic            misalign;
  logic            issue;
  logic            ack_done;
  logic            timeout;
  logic [XLEN-1:0] lmd_aligned;

  assign opcode   = ex_mem_ir[6:0];
  assign funct3   = ex_mem_ir[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && ex_mem_alu[0]) ||
                    ((funct3[1:0] == 2'b10) && (ex_mem_alu[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign issue    = (state == IDLE) && ex_mem_valid && is_mem && !misalign;
  assign ack_done = (state == BUSY) && dmem_ack;
  assign timeout  = (state == BUSY) && !dmem_ack && (wait_cnt == CNT_LAST);

  // The abandoning cycle also releases the stall: the faulting instruction is
  // retired with it, otherwise upstream would present it again and re-issue.
  assign stall_o = !reset && (issue || ((state == BUSY) && !dmem_ack && !timeout));

  // Alignment uses the latched IR/address so it does not depend on upstream holding.
  load_align u_load_align (
    .rdata   (dmem_rdata),
    .funct3  (op_ir[14:12]),
    .addr_lo (op_alu[1:0]),
    .lmd     (lmd_aligned)
  );

  assign fwd_mem_data = (ack_done && !dmem_we) ? lmd_aligned : ex_mem_alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      op_ir        <= '0;
      op_alu       <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'h0;
      dmem_wdata   <= '0;
      mem_wb_valid <= 1'b0;
      mem_wb_ir    <= '0;
      mem_wb_alu   <= '0;
      mem_wb_lmd   <= '0;
      mem_fault    <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (!ex_mem_valid) begin
            mem_wb_valid <= 1'b0;
          end else if (is_mem && misalign) begin
            mem_wb_valid <= 1'b0;
            mem_fault    <= 1'b1;
          end else if (is_mem) begin
            mem_wb_valid <= 1'b0;
            dmem_req     <= 1'b1;
            dmem_we      <= is_store;
            dmem_addr    <= {ex_mem_alu[XLEN-1:2], 2'b00};
            dmem_be      <= is_store ? store_be(funct3, ex_mem_alu[1:0]) : 4'hF;
            dmem_wdata   <= is_store ? store_wdata(funct3, ex_mem_b) : '0;
            op_ir        <= ex_mem_ir;
            op_alu       <= ex_mem_alu;
            state        <= BUSY;
          end else begin
            mem_wb_valid <= 1'b1;
            mem_wb_ir    <= ex_mem_ir;
            mem_wb_alu   <= ex_mem_alu;
            mem_wb_lmd   <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            mem_wb_valid <= 1'b1;
            mem_wb_ir    <= op_ir;
            mem_wb_alu   <= op_alu;
            mem_wb_lmd   <= lmd_aligned;
            state        <= IDLE;
          end else if (timeout) begin
            dmem_req     <= 1'b0;
            mem_fault    <= 1'b1;
            mem_wb_valid <= 1'b0;
            state        <= IDLE;
          end else begin
            wait_cnt     <= wait_cnt + CW'(1);
            mem_wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: randomized scoreboard bench for mem_access_stage with a behavioural memory model.
// Latency: n/a.
// Backpressure: upstream driver holds each bundle while stall_o is high.
module tb_mem_access_stage;

  localparam int ACK_MAX = 15;

  logic        clk;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_ir;
  logic [31:0] ex_mem_alu;
  logic [31:0] ex_mem_b;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_o;
  logic        mem_wb_valid;
  logic [31:0] mem_wb_ir;
  logic [31:0] mem_wb_alu;
  logic [31:0] mem_wb_lmd;
  logic [31:0] fwd_mem_data;
  logic        mem_fault;

  mem_access_stage #(.XLEN(32), .ACK_MAX(ACK_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_mem_valid (ex_mem_valid),
    .ex_mem_ir    (ex_mem_ir),
    .ex_mem_alu   (ex_mem_alu),
    .ex_mem_b     (ex_mem_b),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall_o      (stall_o),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_ir    (mem_wb_ir),
    .mem_wb_alu   (mem_wb_alu),
    .mem_wb_lmd   (mem_wb_lmd),
    .fwd_mem_data (fwd_mem_data),
    .mem_fault    (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] lmd;
  } res_t;

  typedef struct packed {
    int          d;      // index of the busy cycle that gets the ack
    logic [31:0] rdata;
    logic        is_load;
    logic [31:0] lmd;
  } plan_t;

  req_t  req_q[$];
  res_t  res_q[$];
  plan_t plan_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_lmd(input logic [31:0] rd, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * int'(a))) & 32'hFF;
        if (f3 == 3'd0) v = v - ((v & 32'h80) << 1);
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * int'(a / 2'd2))) & 32'hFFFF;
        if (f3 == 3'd1) v = v - ((v & 32'h8000) << 1);
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << (a & 2'd2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] b);
    case (f3[1:0])
      2'd0:    return 32'(b[7:0]) * 32'h01010101;
      2'd1:    return 32'(b[15:0]) * 32'h00010001;
      default: return b;
    endcase
  endfunction

  function automatic bit ref_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return ((f3[1:0] == 2'd1) && (a % 2 != 0)) || ((f3[1:0] == 2'd2) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- memory responder ----------------
  bit          resp_active = 1'b0;
  int          resp_cnt = 0;
  plan_t       resp_cur;
  logic        fwd_vld = 1'b0;
  logic [31:0] fwd_lmd = '0;

  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!dmem_req) begin
        resp_active = 1'b0;
        dmem_ack    = ($urandom_range(0, 5) == 0);   // stray acks must be ignored
        dmem_rdata  = $urandom;
        fwd_vld     = 1'b0;
      end else begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt    = 0;
          if (plan_q.size() == 0) begin
            resp_cur = '{d: 1000, rdata: 32'h0, is_load: 1'b0, lmd: 32'h0};
          end else begin
            resp_cur = plan_q.pop_front();
          end
        end else begin
          resp_cnt++;
        end
        dmem_ack   = (resp_cnt == resp_cur.d);
        dmem_rdata = dmem_ack ? resp_cur.rdata : $urandom;
        fwd_vld    = dmem_ack && resp_cur.is_load;
        fwd_lmd    = resp_cur.lmd;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  req_t snap;

  always @(negedge clk) begin
    res_t r;
    req_t q;
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_fault) begin
        chk32("fault_wb_valid", 32'(mem_wb_valid), 32'd0);
        if (res_q.size() == 0) begin
          chk32("unexpected_fault", 32'(mem_fault), 32'd0);
        end else begin
          r = res_q.pop_front();
          chk32("fault_pulse", 32'(mem_fault), 32'(r.fault));
        end
      end else if (mem_wb_valid) begin
        if (res_q.size() == 0) begin
          chk32("unexpected_wb", 32'(mem_wb_valid), 32'd0);
        end else begin
          r = res_q.pop_front();
          chk32("wb_vs_fault", 32'(mem_fault), 32'(r.fault));
          if (!r.fault) begin
            chk32("wb_ir", mem_wb_ir, r.ir);
            chk32("wb_alu", mem_wb_alu, r.alu);
            chk32("wb_lmd", mem_wb_lmd, r.lmd);
          end
        end
      end

      if (dmem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk32("unexpected_req", 32'(dmem_req), 32'd0);
        end else begin
          q = req_q.pop_front();
          chk32("req_we", 32'(dmem_we), 32'(q.we));
          chk32("req_addr", dmem_addr, q.addr);
          chk32("req_be", 32'(dmem_be), 32'(q.be));
          if (q.we) chk32("req_wdata", dmem_wdata, q.wdata);
        end
      end else if (dmem_req && prev_req) begin
        chk32("req_hold_addr", dmem_addr, snap.addr);
        chk32("req_hold_ctl", {27'd0, dmem_we, dmem_be}, {27'd0, snap.we, snap.be});
        chk32("req_hold_wdata", dmem_wdata, snap.wdata);
      end
      snap     = '{we: dmem_we, addr: dmem_addr, be: dmem_be, wdata: dmem_wdata};
      prev_req = dmem_req;

      chk32("fwd_mem_data", fwd_mem_data, fwd_vld ? fwd_lmd : ex_mem_alu);
    end
  end

  // ---------------- driver ----------------
  task automatic present(input logic v, input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] b, input int d, input logic [31:0] rdata);
    logic [2:0]  f3;
    logic        is_ld;
    logic        is_st;
    logic [31:0] lmd;
    int          exp_held;
    int          held;
    f3       = ir[14:12];
    is_ld    = (ir[6:0] == 7'b0000011);
    is_st    = (ir[6:0] == 7'b0100011);
    exp_held = 1;
    if (v && (is_ld || is_st)) begin
      if (ref_misalign(f3, alu)) begin
        res_q.push_back('{fault: 1'b1, ir: ir, alu: alu, lmd: 32'h0});
      end else begin
        lmd = ref_lmd(rdata, f3, alu[1:0]);
        req_q.push_back('{we: is_st, addr: alu & 32'hFFFF_FFFC,
                          be: is_st ? ref_be(f3, alu[1:0]) : 4'hF,
                          wdata: ref_wdata(f3, b)});
        plan_q.push_back('{d: d, rdata: rdata, is_load: is_ld, lmd: lmd});
        res_q.push_back('{fault: (d >= ACK_MAX), ir: ir, alu: alu, lmd: lmd});
        exp_held = 2 + ((d < ACK_MAX - 1) ? d : ACK_MAX - 1);
      end
    end else if (v) begin
      res_q.push_back('{fault: 1'b0, ir: ir, alu: alu, lmd: 32'h0});
    end
    ex_mem_valid = v;
    ex_mem_ir    = ir;
    ex_mem_alu   = alu;
    ex_mem_b     = b;
    held = 0;
    do begin
      @(negedge clk);
      held++;
    end while (stall_o && held < 64);
    @(posedge clk);
    #1;
    chk32("stall_cycles", 32'(held), 32'(exp_held));
  endtask

  task automatic check_zero(input string tag);
    chk32({tag, "_req"}, {27'd0, dmem_req, dmem_we, stall_o, mem_wb_valid, mem_fault}, 32'd0);
    chk32({tag, "_addr"}, dmem_addr, 32'd0);
    chk32({tag, "_be"}, 32'(dmem_be), 32'd0);
    chk32({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk32({tag, "_wb_ir"}, mem_wb_ir, 32'd0);
    chk32({tag, "_wb_alu"}, mem_wb_alu, 32'd0);
    chk32({tag, "_wb_lmd"}, mem_wb_lmd, 32'd0);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  op;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) begin
      op = 7'b0000011;
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
    end else if (k < 6) begin
      op = 7'b0100011;
      f3 = 3'($urandom_range(0, 2));
    end else begin
      op = r[6:0];
      if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0110011;
      f3 = r[14:12];
    end
    return {r[31:15], f3, r[11:7], op};
  endfunction

  initial begin
    reset        = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_ir    = '0;
    ex_mem_alu   = '0;
    ex_mem_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // directed cases
    present(1'b1, 32'h002081B3, 32'h0000_1234, 32'h0, 0, 32'h0);              // ADD pass-through
    present(1'b1, 32'h0020A283, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);      // LW, ack 3 later
    present(1'b1, 32'h00008283, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F);      // LB
    present(1'b1, 32'h0000C283, 32'h0000_0103, 32'h0, 1, 32'h80FF_FF7F);      // LBU
    present(1'b1, 32'h00209023, 32'h0000_0202, 32'h0000_ABCD, 2, 32'h0);      // SH
    present(1'b1, 32'h0020A283, 32'h0000_0400, 32'h0, ACK_MAX, 32'h0);        // LW timeout
    present(1'b0, 32'h0020A283, 32'h0000_0500, 32'h0, 0, 32'h0);              // bubble
    present(1'b1, 32'h0020A283, 32'h0000_0101, 32'h0, 0, 32'h1122_3344);      // misaligned LW

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? ACK_MAX + $urandom_range(0, 2) : $urandom_range(0, 5);
      present(($urandom_range(0, 7) != 0), rand_ir(), $urandom, $urandom, d, $urandom);
    end

    // reset while a load is outstanding
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0600, be: 4'hF, wdata: 32'h0});
    plan_q.push_back('{d: 1000, rdata: 32'h0, is_load: 1'b1, lmd: 32'h0});
    ex_mem_valid = 1'b1;
    ex_mem_ir    = 32'h0020A283;
    ex_mem_alu   = 32'h0000_0600;
    repeat (2) @(posedge clk);
    #1;
    chk32("busy_req_high", 32'(dmem_req), 32'd1);
    reset        = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_ir    = '0;
    ex_mem_alu   = '0;
    @(posedge clk);
    #1;
    check_zero("midbusy_reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk32("res_q_drained", 32'(res_q.size()), 32'd0);
    chk32("req_q_drained", 32'(req_q.size()), 32'd0);
    chk32("plan_q_drained", 32'(plan_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
